// File: rtl/uart_tx_controller_if.sv
// -----------------------------------------------------------------------------
// uart_tx_controller_if
// Byte handshake between a requester and the UART transmitter.
//   tx_valid : requester -> transmitter, a byte is offered
//   tx_data  : requester -> transmitter, the byte (sampled only on acceptance)
//   tx_ready : transmitter -> requester, a byte can be accepted this cycle
// A byte moves on a rising clock edge where tx_valid and tx_ready are both 1.
// Modports: master = requester side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_controller_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;

   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_controller.sv
// -----------------------------------------------------------------------------
// uart_tx_controller
// 8N1 UART transmitter: one start bit (0), eight data bits LSB first, one stop
// bit (1). Each bit is held for CLKS_PER_BIT clock cycles, so a frame takes
// 10*CLKS_PER_BIT cycles from the acceptance edge back to IDLE.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit, 2..65535
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : asynchronous active-high reset, aborts any frame in flight
//   host      : byte handshake (tx_valid / tx_data in, tx_ready out)
//   tx_out    : serial line, idle high
//   bit_index : index of the data bit currently on the line (0 outside DATA)
//   busy      : a frame is in progress (inverse of tx_ready)
//   tx_done   : one-cycle pulse in the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_controller #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   uart_tx_controller_if.slave        host,
   output logic                       tx_out,
   output logic [2:0]                 bit_index,
   output logic                       busy,
   output logic                       tx_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Counter value on the last cycle of a bit period.
   localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);

   state_t      state_reg,    state_next;
   logic [15:0] baud_cnt_reg, baud_cnt_next;
   logic [7:0]  data_reg,     data_next;
   logic [2:0]  bit_idx_reg,  bit_idx_next;

   logic        bit_end;
   logic        ready_c;
   logic        tx_out_c;
   logic        done_c;

   assign bit_end = (baud_cnt_reg == BIT_END);

   // -------------------------------------------------------------------------
   // State and datapath registers. Everything is cleared asynchronously so the
   // line returns high and the handshake opens the instant reset is seen.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= 16'd0;
         data_reg     <= 8'd0;
         bit_idx_reg  <= 3'd0;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         data_reg     <= data_next;
         bit_idx_reg  <= bit_idx_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic. The baud counter free-runs by default and is
   // forced to zero on every state entry and every bit advance, so each bit
   // period is exactly CLKS_PER_BIT cycles long.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg + 16'd1;
      data_next     = data_reg;
      bit_idx_next  = bit_idx_reg;
      ready_c       = 1'b0;
      tx_out_c      = 1'b1;
      done_c        = 1'b0;

      unique case (state_reg)
         IDLE: begin
            ready_c       = 1'b1;
            baud_cnt_next = 16'd0;
            bit_idx_next  = 3'd0;
            if (host.tx_valid) begin
               // The byte is captured here and never looked at again, so
               // later changes on tx_data cannot reach the frame in flight.
               data_next  = host.tx_data;
               state_next = START;
            end
         end

         START: begin
            tx_out_c = 1'b0;
            if (bit_end) begin
               state_next    = DATA;
               baud_cnt_next = 16'd0;
               bit_idx_next  = 3'd0;
            end
         end

         DATA: begin
            tx_out_c = data_reg[bit_idx_reg];
            if (bit_end) begin
               baud_cnt_next = 16'd0;
               if (bit_idx_reg == 3'd7) begin
                  // Leave DATA instead of wrapping the index back to 0.
                  state_next   = STOP;
                  bit_idx_next = 3'd0;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end
         end

         STOP: begin
            tx_out_c = 1'b1;
            if (bit_end) begin
               done_c        = 1'b1;
               state_next    = IDLE;
               baud_cnt_next = 16'd0;
            end
         end

         default: begin
            state_next    = IDLE;
            baud_cnt_next = 16'd0;
            bit_idx_next  = 3'd0;
         end
      endcase
   end

   // Outputs are decoded from registered state only, so they follow reset
   // immediately and stay glitch-free relative to clk.
   assign host.tx_ready = ready_c;
   assign busy          = ~ready_c;
   assign tx_out        = tx_out_c;
   assign tx_done       = done_c;
   assign bit_index     = bit_idx_reg;

endmodule

// File: tb/tb_uart_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_controller
// Scoreboard bench for uart_tx_controller with CLKS_PER_BIT = 4. Stimulus
// pushes each accepted byte into a queue; an independent monitor watches the
// serial line, pops the byte when a start bit appears and compares every
// cycle of the frame against the 10-bit 8N1 image of that byte.
// -----------------------------------------------------------------------------
module tb_uart_tx_controller;
   localparam int C     = 4;
   localparam int FRAME = 10 * C;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_out;
   logic [2:0] bit_index;
   logic       busy;
   logic       tx_done;

   uart_tx_controller_if bus ();

   uart_tx_controller #(.CLKS_PER_BIT(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .host      (bus),
      .tx_out    (tx_out),
      .bit_index (bit_index),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   bit         mon_active = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Offer a byte and wait for the acceptance edge. Call only when the
   // handshake signals are stable (just after a posedge or at a negedge).
   task automatic send(input logic [7:0] b, input bit hold, output int acc_cyc);
      int n;
      n = 0;
      acc_cyc = -1;
      bus.tx_valid = 1'b1;
      bus.tx_data  = b;
      while (bus.tx_ready !== 1'b1) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'(n), 32'd0);
            bus.tx_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      exp_q.push_back(b);
      #1;
      acc_cyc = cyc;
      if (!hold) bus.tx_valid = 1'b0;
      $display("tx accept byte=%02h cycle=%0d", b, acc_cyc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 || mon_active) begin
         @(negedge clk);
         n++;
         if (n > 2000) begin
            chk("drain_timeout", 32'(n), 32'd0);
            return;
         end
      end
      @(negedge clk);
   endtask

   // -------------------------------------------------------------------------
   // Monitor: reference frame is {stop=1, data, start=0}, each bit held C
   // samples; tx_done only on sample FRAME; bit_index = data bit number.
   // -------------------------------------------------------------------------
   initial begin
      int         s;
      int         bn;
      logic [9:0] frame;
      logic [7:0] b;
      s = 0;
      frame = 10'h3FF;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            if (mon_active) $display("frame aborted by reset at sample %0d", s);
            mon_active = 1'b0;
            chk("rst_tx_out", 32'(tx_out), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(tx_done), 32'd0);
         end else begin
            if (!mon_active && tx_out === 1'b0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
               end else begin
                  b          = exp_q.pop_front();
                  frame      = {1'b1, b, 1'b0};
                  mon_active = 1'b1;
                  s          = 1;
               end
            end
            if (mon_active) begin
               bn = (s - 1) / C;
               chk("frame_tx_out", 32'(tx_out), 32'(frame[bn]));
               chk("frame_bit_index", 32'(bit_index),
                   (bn >= 1 && bn <= 8) ? 32'(bn - 1) : 32'd0);
               chk("frame_busy", 32'(busy), 32'd1);
               chk("frame_ready", 32'(bus.tx_ready), 32'd0);
               chk("frame_done", 32'(tx_done), (s == FRAME) ? 32'd1 : 32'd0);
               if (s == FRAME) begin
                  mon_active = 1'b0;
                  $display("rx frame byte=%02h complete cycle=%0d", frame[8:1], cyc);
               end else begin
                  s++;
               end
            end else if (tx_out === 1'b1) begin
               chk("idle_ready", 32'(bus.tx_ready), 32'd1);
               chk("idle_busy", 32'(busy), 32'd0);
               chk("idle_done", 32'(tx_done), 32'd0);
               chk("idle_bit_index", 32'(bit_index), 32'd0);
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      int a1, a2, rel, n;
      logic [7:0] rb;

      reset        = 1'b1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_tx_out", 32'(tx_out), 32'd1);
      chk("post_reset_ready", 32'(bus.tx_ready), 32'd1);
      chk("post_reset_busy", 32'(busy), 32'd0);
      chk("post_reset_bit_index", 32'(bit_index), 32'd0);
      chk("post_reset_done", 32'(tx_done), 32'd0);

      // Single frame of 0xA5.
      send(8'hA5, 1'b0, a1);
      drain();

      // Data changes and a stray valid pulse while busy must not matter.
      send(8'h3C, 1'b0, a1);
      bus.tx_data = 8'hFF;
      repeat (10) @(negedge clk);
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      drain();

      // Back-to-back with tx_valid held: one idle cycle between frames.
      send(8'h01, 1'b1, a1);
      bus.tx_data = 8'h80;
      send(8'h80, 1'b0, a2);
      chk("b2b_gap", 32'(a2 - a1), 32'(FRAME + 1));
      drain();

      // Randomised bytes with random gaps.
      for (int i = 0; i < 8; i++) begin
         rb = 8'($urandom_range(0, 255));
         send(rb, 1'b0, a1);
         repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk);
      end
      drain();

      // Asynchronous reset in the middle of 0x55 at bit_index 3.
      send(8'h55, 1'b0, a1);
      n = 0;
      while (!(busy === 1'b1 && bit_index === 3'd3) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_bit3", 32'(bit_index), 32'd3);
      #2;
      reset = 1'b1;
      #1;
      chk("async_tx_out", 32'(tx_out), 32'd1);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_ready", 32'(bus.tx_ready), 32'd1);
      chk("async_bit_index", 32'(bit_index), 32'd0);
      chk("async_done", 32'(tx_done), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rel = cyc;
      send(8'h0F, 1'b0, a1);
      chk("first_edge_accept", 32'(a1), 32'(rel + 1));
      drain();

      // Quiet line: 50 cycles with tx_valid low.
      bus.tx_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("quiet_tx_out", 32'(tx_out), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/uart_tx_controller.md
UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Parameters
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the clock cycles per serial bit period; the legal range is 2..65535.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tx_valid, input, 1 bit: the requester has a byte to send.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte to send, sampled only on acceptance.
REQ-006 The block SHALL have port tx_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-007 The block SHALL have port tx_out, output, 1 bit: the serial line, idle-high.
REQ-008 The block SHALL have port bit_index, output, 3 bits: index of the data bit being shifted, driven to the downstream bit-index decoder/mux.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP, encoded in 2 bits.
REQ-012 Handshake: a byte SHALL be accepted on the rising edge where tx_valid=1 and tx_ready=1; tx_data is latched into an internal 8-bit shift register and the state goes IDLE->START.
REQ-013 tx_ready SHALL be 1 only in IDLE; busy SHALL equal NOT tx_ready.
REQ-014 Baud counter: 16 bits; it SHALL be cleared on every state entry and on every bit advance, and it increments each cycle; a bit period ends on the cycle where counter = CLKS_PER_BIT-1.
REQ-015 START SHALL drive tx_out=0 for CLKS_PER_BIT cycles, then enter DATA with bit_index=0.
REQ-016 DATA SHALL drive tx_out = latched_data[bit_index], LSB first; at each bit-period end, bit_index increments; after the period with bit_index=7 the state goes to STOP.
REQ-017 bit_index SHALL be 0 outside DATA and SHALL NOT wrap from 7 to 0 within a frame.
REQ-018 STOP SHALL drive tx_out=1 for CLKS_PER_BIT cycles; tx_done=1 in the final STOP cycle only; the next state is IDLE.
REQ-019 IDLE SHALL drive tx_out=1.
REQ-020 A frame SHALL last exactly 10*CLKS_PER_BIT cycles from the acceptance edge to the IDLE entry.
REQ-021 tx_valid and tx_data changes while busy SHALL be ignored and SHALL NOT alter the frame in flight.
REQ-022 Back-to-back: with tx_valid held high, the next byte SHALL be accepted in the first IDLE cycle after tx_done, giving exactly one idle-high cycle between frames.
REQ-023 The block SHALL have no latches; every output SHALL be driven in every state.

Reset
REQ-024 reset=1 SHALL immediately, without waiting for a clk edge, force state=IDLE, tx_out=1, tx_ready=1, busy=0, tx_done=0, bit_index=0, baud counter=0, shift register=0.
REQ-025 Reset mid-frame SHALL abort the frame with no tx_done pulse; after release the block SHALL accept a new byte on the first edge with tx_valid=1.

Verification (CLKS_PER_BIT=4)
REQ-026 The bench SHALL cover: reset asserted for 3 cycles then released -> tx_out=1, tx_ready=1, busy=0, bit_index=0, tx_done=0.
REQ-027 The bench SHALL cover: accept 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles; bit_index steps 0..7 every 4 cycles; tx_done high for 1 cycle at cycle 40 after acceptance.
REQ-028 The bench SHALL cover: tx_data changed to 0xFF while sending 0x3C -> the serialized bits still equal 0x3C, LSB first.
REQ-029 The bench SHALL cover: tx_valid held high with 0x01 then 0x80 -> two frames separated by exactly 1 idle-high cycle; tx_ready high only in that cycle.
REQ-030 The bench SHALL cover: reset asserted at bit_index=3 of 0x55 -> tx_out=1 and busy=0 asynchronously, no tx_done; then send 0x0F -> a correct frame.
REQ-031 The bench SHALL cover: tx_valid=0 for 50 cycles -> tx_out stays 1, no state change.
